procyon_ccu_mhq_sched: RTL

- Scheduler for the CCU miss handling queue (MHQ) entry array.
- Allocates free entries to new LSU misses and keeps allocation order in an index FIFO.
- Sequences one outstanding CCU fetch at a time, oldest first, and routes the CCU completion to the owning entry.
- Selects complete entries for DCache fill launch to the LSU. Sits in procyon_ccu between the MHQ entries and the CCU memory interface.

---
 rtl/procyon_ccu_mhq_sched_pkg.sv | 16 +
 rtl/procyon_ccu_mhq_sched_if.sv | 43 ++++
 rtl/procyon_ccu_mhq_sched_fifo.sv | 53 +++++
 rtl/procyon_ccu_mhq_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/procyon_ccu_mhq_sched_pkg.sv
// Shared types and constants for the CCU miss handling queue scheduler.
package procyon_ccu_mhq_sched_pkg;

  localparam int DC_OFFSET_WIDTH = 5;

  typedef enum logic [1:0] {
    MHQ_SCHED_IDLE = 2'b00,
    MHQ_SCHED_REQ  = 2'b01,
    MHQ_SCHED_WAIT = 2'b10
  } mhq_sched_state_t;

  function automatic int mhq_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/procyon_ccu_mhq_sched_if.sv
// Bundle between the MHQ entry array / LSU / CCU side and the MHQ scheduler.
interface procyon_ccu_mhq_sched_if #(
  parameter int OPTN_MHQ_DEPTH  = 4,
  parameter int OPTN_ADDR_WIDTH = 32
);
  import procyon_ccu_mhq_sched_pkg::*;

  localparam int MHQ_IDX_WIDTH = mhq_idx_width(OPTN_MHQ_DEPTH);
  localparam int LINE_W        = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH;

  logic [OPTN_MHQ_DEPTH-1:0]             i_mhq_entry_valid;
  logic [OPTN_MHQ_DEPTH-1:0]             i_mhq_entry_complete;
  logic [OPTN_MHQ_DEPTH-1:0][LINE_W-1:0] i_mhq_entry_addr;
  logic                                  i_alloc_req;
  logic                                  o_alloc_ack;
  logic [OPTN_MHQ_DEPTH-1:0]             o_alloc_en;
  logic                                  o_mhq_full;
  logic                                  o_ccu_req;
  logic [MHQ_IDX_WIDTH-1:0]              o_ccu_idx;
  logic [LINE_W-1:0]                     o_ccu_addr;
  logic                                  i_ccu_ack;
  logic                                  i_ccu_done;
  logic [OPTN_MHQ_DEPTH-1:0]             o_ccu_done;
  logic                                  o_fill_valid;
  logic [MHQ_IDX_WIDTH-1:0]              o_fill_idx;
  logic                                  i_fill_ready;
  logic [OPTN_MHQ_DEPTH-1:0]             o_fill_launched;

  modport sched (
    input  i_mhq_entry_valid, i_mhq_entry_complete, i_mhq_entry_addr, i_alloc_req,
           i_ccu_ack, i_ccu_done, i_fill_ready,
    output o_alloc_ack, o_alloc_en, o_mhq_full, o_ccu_req, o_ccu_idx, o_ccu_addr,
           o_ccu_done, o_fill_valid, o_fill_idx, o_fill_launched
  );

  modport mhq (
    output i_mhq_entry_valid, i_mhq_entry_complete, i_mhq_entry_addr, i_alloc_req,
           i_ccu_ack, i_ccu_done, i_fill_ready,
    input  o_alloc_ack, o_alloc_en, o_mhq_full, o_ccu_req, o_ccu_idx, o_ccu_addr,
           o_ccu_done, o_fill_valid, o_fill_idx, o_fill_launched
  );

endinterface

// File: rtl/procyon_ccu_mhq_sched_fifo.sv
// Circular FIFO of MHQ entry indices recording allocation order.
module procyon_ccu_mhq_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [IDX_W-1:0]           push_idx_i,
  input  logic                       pop_i,
  output logic [IDX_W-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [IDX_W-1:0] slots_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = pop_i  ? head_q + IDX_W'(1) : head_q;
    tail_d  = push_i ? tail_q + IDX_W'(1) : tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot contents are only meaningful below count, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_i) slots_q[tail_q] <= push_idx_i;
  end

  assign head_o  = slots_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/procyon_ccu_mhq_sched.sv
// MHQ scheduler: entry allocation, in-order single-outstanding CCU fetch, fill select.
// Optional build macro PCYN_MHQ_SCHED_FILL_RR_EN makes fill selection round-robin.
module procyon_ccu_mhq_sched
  import procyon_ccu_mhq_sched_pkg::*;
#(
  parameter int OPTN_MHQ_DEPTH  = 4,
  parameter int OPTN_ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  procyon_ccu_mhq_sched_if.sched bus
);

  localparam int D     = OPTN_MHQ_DEPTH;
  localparam int IDX_W = mhq_idx_width(OPTN_MHQ_DEPTH);
  localparam int CNT_W = $clog2(OPTN_MHQ_DEPTH+1);

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [D-1:0] vec);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = D-1; i >= 0; i--) begin
      if (vec[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [D-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [D-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_ack;
  logic [IDX_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_pop;
  logic             in_req;
  logic             in_wait;
  logic [IDX_W-1:0] fill_idx;
  logic             fill_launch;
  mhq_sched_state_t state_q;
  logic [IDX_W-1:0] ccu_idx_q;

  assign bus.o_mhq_full  = &bus.i_mhq_entry_valid;
  assign alloc_idx       = lowest_idx(~bus.i_mhq_entry_valid);
  assign alloc_ack       = bus.i_alloc_req & ~bus.o_mhq_full;
  assign bus.o_alloc_ack = alloc_ack;
  assign bus.o_alloc_en  = onehot(alloc_idx) & {D{alloc_ack}};

  assign in_req   = (state_q == MHQ_SCHED_REQ);
  assign in_wait  = (state_q == MHQ_SCHED_WAIT);
  assign fifo_pop = in_req & bus.i_ccu_ack;

  procyon_ccu_mhq_sched_fifo #(
    .DEPTH(D),
    .IDX_W(IDX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (alloc_ack),
    .push_idx_i(alloc_idx),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .count_o   (fifo_count)
  );

  // Looking at the push as well as the count lets a fresh allocation request next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MHQ_SCHED_IDLE;
      ccu_idx_q <= '0;
    end else begin
      case (state_q)
        MHQ_SCHED_IDLE: if ((fifo_count != '0) || alloc_ack) state_q <= MHQ_SCHED_REQ;
        MHQ_SCHED_REQ: begin
          if (bus.i_ccu_ack) begin
            ccu_idx_q <= fifo_head;
            state_q   <= MHQ_SCHED_WAIT;
          end
        end
        MHQ_SCHED_WAIT: if (bus.i_ccu_done) state_q <= MHQ_SCHED_IDLE;
        default:        state_q <= MHQ_SCHED_IDLE;
      endcase
    end
  end

  assign bus.o_ccu_req  = in_req;
  assign bus.o_ccu_idx  = in_req ? fifo_head : '0;
  assign bus.o_ccu_addr = in_req ? bus.i_mhq_entry_addr[fifo_head] : '0;
  assign bus.o_ccu_done = onehot(ccu_idx_q) & {D{in_wait & bus.i_ccu_done}};

  assign bus.o_fill_valid    = |bus.i_mhq_entry_complete;
  assign fill_launch         = bus.o_fill_valid & bus.i_fill_ready;
  assign bus.o_fill_idx      = fill_idx;
  assign bus.o_fill_launched = onehot(fill_idx) & {D{fill_launch}};

`ifdef PCYN_MHQ_SCHED_FILL_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_probe;

  // Scan downward so the closest complete entry at or after the pointer wins.
  always_comb begin
    fill_idx = '0;
    rr_probe = '0;
    for (int i = D-1; i >= 0; i--) begin
      rr_probe = rr_ptr_q + IDX_W'(i);
      if (bus.i_mhq_entry_complete[rr_probe]) fill_idx = rr_probe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else if (fill_launch) rr_ptr_q <= fill_idx + IDX_W'(1);
  end
`else
  assign fill_idx = lowest_idx(bus.i_mhq_entry_complete);
`endif

endmodule
